handshake_control_merge_rr: RTL and testbench

Round-robin control merge for the handshake dataflow fabric. It arbitrates among `NUM_INPUTS` incoming control tokens and forwards one token per cycle. Each forwarded token goes out on a control output channel together with the winning input's index on a separate index channel. Its main use is sequencing a shared dataflow resource, such as a handshake constant source or a mux select, between several control paths. A one-entry output register holds each token, and an eager fork lets the two output channels complete independently.

---
 rtl/handshake_control_merge_rr.sv | 104 ++++++++++
 tb/tb_handshake_control_merge_rr.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/handshake_control_merge_rr.sv
// Round-robin control merge. It holds one token in an output register and
// forks it to a control channel and an index channel that complete independently.
module handshake_control_merge_rr #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,          // async, active low
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   index_valid,
  input  logic                   index_ready
);

  localparam int                     IW1  = INDEX_WIDTH + 1;
  localparam logic [IW1-1:0]         N_W  = IW1'(NUM_INPUTS);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic                   full_q, full_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic                   outs_done_q, outs_done_d;
  logic                   index_done_q, index_done_d;
  logic [INDEX_WIDTH-1:0] prio_q, prio_d;

  logic                   complete, load_en, accept;
  logic [NUM_INPUTS-1:0]  rot;
  logic [IW1-1:0]         off, sum;
  logic                   gnt_vld;
  logic [INDEX_WIDTH-1:0] gnt_idx;

  assign outs_valid  = full_q & ~outs_done_q;
  assign index_valid = full_q & ~index_done_q;
  assign index       = idx_q;

  assign complete = full_q & (outs_done_q | outs_ready) & (index_done_q | index_ready);
  assign load_en  = ~full_q | complete;

  // Arbitration: rotate requests so prio sits at bit 0, take the lowest set
  // bit, then rotate the winner's position back into an absolute index.
  always_comb begin
    rot     = NUM_INPUTS'({ins_valid, ins_valid} >> prio_q);
    gnt_vld = |rot;
    off     = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (rot[i]) off = IW1'(i);
    end
    sum = {1'b0, prio_q} + off;
    if (sum >= N_W) sum = sum - N_W;
    gnt_idx = sum[INDEX_WIDTH-1:0];
  end

  // One-hot ready to the winner; held at zero while reset is asserted.
  always_comb begin
    ins_ready = '0;
    if (rst && gnt_vld && load_en) ins_ready = NUM_INPUTS'(1) << gnt_idx;
  end

  assign accept = |(ins_valid & ins_ready);

  // Next state: an accept reloads the register (and wins over completion),
  // otherwise a completed token leaves, otherwise record partial delivery.
  always_comb begin
    full_d       = full_q;
    idx_d        = idx_q;
    outs_done_d  = outs_done_q;
    index_done_d = index_done_q;
    prio_d       = prio_q;
    if (accept) begin
      full_d       = 1'b1;
      idx_d        = gnt_idx;
      outs_done_d  = 1'b0;
      index_done_d = 1'b0;
      prio_d       = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end else if (complete) begin
      full_d       = 1'b0;
      outs_done_d  = 1'b0;
      index_done_d = 1'b0;
    end else if (full_q) begin
      outs_done_d  = outs_done_q  | (outs_valid  & outs_ready);
      index_done_d = index_done_q | (index_valid & index_ready);
    end
  end

  // State register; reset drops any held or partially delivered token.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q       <= 1'b0;
      idx_q        <= '0;
      outs_done_q  <= 1'b0;
      index_done_q <= 1'b0;
      prio_q       <= '0;
    end else begin
      full_q       <= full_d;
      idx_q        <= idx_d;
      outs_done_q  <= outs_done_d;
      index_done_q <= index_done_d;
      prio_q       <= prio_d;
    end
  end

endmodule

// File: tb/tb_handshake_control_merge_rr.sv
// Scoreboard bench for the round-robin control merge: a 4-input instance for
// the directed scenarios and a 3-input instance for the non-power-of-two wrap.
module tb_handshake_control_merge_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ins_valid, ins_ready;
  logic       outs_valid, outs_ready, index_valid, index_ready;
  logic [1:0] index;

  logic       rst3;
  logic [2:0] b_valid, b_ready;
  logic       b_outs_valid, b_index_valid;
  logic [1:0] b_index;

  int checks = 0;
  int errors = 0;
  int exp_o[$];
  int exp_i[$];
  int exp_b[$];

  always #5 clk = ~clk;

  handshake_control_merge_rr #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs_valid(outs_valid), .outs_ready(outs_ready), .index(index),
    .index_valid(index_valid), .index_ready(index_ready));

  handshake_control_merge_rr #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst3), .ins_valid(b_valid), .ins_ready(b_ready),
    .outs_valid(b_outs_valid), .outs_ready(1'b1), .index(b_index),
    .index_valid(b_index_valid), .index_ready(1'b1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expected index for every delivered token on each channel.
  always @(negedge clk) begin
    if (rst && outs_valid && outs_ready) begin
      if (exp_o.size() == 0) chk("outs_unexpected", 1, 0);
      else chk("outs_token_index", 32'(index), 32'(exp_o.pop_front()));
    end
    if (rst && index_valid && index_ready) begin
      if (exp_i.size() == 0) chk("index_unexpected", 1, 0);
      else chk("index_token", 32'(index), 32'(exp_i.pop_front()));
    end
    if (rst3 && b_index_valid) begin
      chk("n3_outs_valid", 32'(b_outs_valid), 1);
      if (exp_b.size() == 0) chk("n3_unexpected", 1, 0);
      else chk("n3_index", 32'(b_index), 32'(exp_b.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ins_valid = 4'b1111; outs_ready = 1'b1; index_ready = 1'b1;
    rst3 = 1'b0; b_valid = 3'b000;
    repeat (3) step();

    // Reset holds everything quiet even with all requests up
    @(negedge clk);
    chk("rst_ins_ready", 32'(ins_ready), 0);
    chk("rst_outs_valid", 32'(outs_valid), 0);
    chk("rst_index_valid", 32'(index_valid), 0);
    chk("rst_index", 32'(index), 0);

    // Full load: grants 0,1,2,3,0,1 back to back
    @(posedge clk); #1;
    rst = 1'b1;
    foreach (exp_o[i]) ;
    for (int i = 0; i < 6; i++) begin
      exp_o.push_back(i % 4);
      exp_i.push_back(i % 4);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_ins_ready", 32'(ins_ready), 32'(4'b0001 << (i % 4)));
      if (i > 0) chk("full_outs_valid", 32'(outs_valid), 1);
      step();
    end
    ins_valid = 4'b0000;
    @(negedge clk);
    chk("full_last_outs_valid", 32'(outs_valid), 1);
    step(); step();

    // Non-power-of-two instance: 0,1,2,0
    for (int i = 0; i < 4; i++) exp_b.push_back(i % 3);
    rst3 = 1'b1; b_valid = 3'b111;
    repeat (4) step();
    b_valid = 3'b000;
    step(); step();

    // Sparse requests from prio 0: 1,3,1,3
    rst = 1'b0;
    step();
    rst = 1'b1; ins_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_o.push_back((i % 2) ? 3 : 1);
      exp_i.push_back((i % 2) ? 3 : 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sparse_ins_ready", 32'(ins_ready), (i % 2) ? 32'b1000 : 32'b0010);
      step();
    end
    ins_valid = 4'b0000;
    step(); step();

    // Fork backpressure on the index channel with token 2 held
    ins_valid = 4'b0100;
    @(negedge clk);
    chk("fork_load_ready", 32'(ins_ready), 32'b0100);
    exp_o.push_back(2); exp_i.push_back(2);
    step();
    ins_valid = 4'b0001; index_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fork_outs_valid", 32'(outs_valid), (i == 0) ? 1 : 0);
      chk("fork_index_valid", 32'(index_valid), 1);
      chk("fork_index", 32'(index), 2);
      chk("fork_ins_ready", 32'(ins_ready), 0);
      step();
    end
    exp_o.push_back(0); exp_i.push_back(0);
    index_ready = 1'b1;
    @(negedge clk);
    chk("fork_reload_ready", 32'(ins_ready), 32'b0001);
    chk("fork_done_outs_valid", 32'(outs_valid), 0);
    step();
    ins_valid = 4'b0000;
    @(negedge clk);
    chk("fork_next_valid", 32'(outs_valid), 1);
    chk("fork_next_index", 32'(index), 0);
    step(); step();

    // Reset mid-operation with prio advanced to 2
    ins_valid = 4'b0010; outs_ready = 1'b0; index_ready = 1'b0;
    @(negedge clk);
    chk("mid_load_ready", 32'(ins_ready), 32'b0010);
    step();
    ins_valid = 4'b0101;
    @(negedge clk);
    chk("mid_held_outs_valid", 32'(outs_valid), 1);
    chk("mid_held_index", 32'(index), 1);
    chk("mid_held_ins_ready", 32'(ins_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_async_outs_valid", 32'(outs_valid), 0);
    chk("mid_async_index_valid", 32'(index_valid), 0);
    chk("mid_async_index", 32'(index), 0);
    chk("mid_async_ins_ready", 32'(ins_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1; outs_ready = 1'b1; index_ready = 1'b1;
    exp_o.push_back(0); exp_i.push_back(0);
    @(negedge clk);
    chk("mid_release_ready", 32'(ins_ready), 32'b0001);
    step();
    ins_valid = 4'b0000;
    step(); step();

    chk("drain_outs", 32'(exp_o.size()), 0);
    chk("drain_index", 32'(exp_i.size()), 0);
    chk("drain_n3", 32'(exp_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
